pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline stall/flush controller for the five-stage core. Merges stall requests from ID and EX, inserts a configurable number of memory wait states for MEM-stage loads/stores, and resolves exceptions into a flush plus exception-handler PC. Drives the 6-bit `stall` vector consumed by the pc_reg, if_id, id_ex, ex_mem and mem_wb pipeline registers.

## Interface
- `MEM_WAIT`, 2: wait-state cycles inserted per MEM access; legal 0..15.
- `EXC_VECTOR`, 32'h0000_0020: handler entry address for all non-eret exceptions.
- `STALL_LIMIT`, 1024: consecutive-stall cycle count that trips the watchdog; legal 1..65535.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stallreq_id` in 1: ID stall request, e.g. a load-use hazard.
- `stallreq_ex` in 1: EX stall request, e.g. a multicycle mult/div.
- `mem_req_i` in 1: MEM stage holds a load/store; held high until that instruction leaves MEM.
- `excepttype_i` in 32: exception code from MEM; 0 = none, 32'h0000_000e = eret.
- `cp0_epc_i` in 32: current CP0 EPC.
- `stall` out 6: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = hold.
- `flush` out 1: clear all pipeline registers this cycle.
- `new_pc` out 32: redirect target; valid only while `flush`=1, else 0.
- `stall_timeout` out 1: sticky watchdog flag.

## Operation
- FSM states RUN, WAIT, DONE; 4-bit down-counter `wcnt`.
- Stall priority, highest first: flush > memory wait > `stallreq_ex` > `stallreq_id`.
  - Memory wait: `stall`=6'b011111.
  - `stallreq_ex`: `stall`=6'b001111.
  - `stallreq_id`: `stall`=6'b000111.
  - None of the above: `stall`=6'b000000.
- RUN with `mem_req_i`=1 and MEM_WAIT>0:
  - memory wait applies this cycle;
  - `wcnt` <= MEM_WAIT-1;
  - if MEM_WAIT=1 go to DONE, else go to WAIT.
- WAIT: memory wait applies; `wcnt` decrements each cycle; go to DONE when `wcnt` is 1 at the edge.
- DONE:
  - no memory wait; `mem_req_i` is ignored, so the finishing instruction cannot retrigger;
  - lower-priority requests still apply;
  - go to RUN next cycle.
- MEM_WAIT=0: no memory wait ever; FSM stays in RUN.
- Memory wait holds `stall[4]`, so mem_wb keeps its contents throughout.
- Exception (`excepttype_i`≠0) in any state:
  - `flush`=1 and `stall`=0 in the same cycle;
  - `new_pc`=`cp0_epc_i` for eret, else EXC_VECTOR;
  - next state RUN, `wcnt`<=0.
- `stallreq_*` coincident with an exception is discarded.
- `rst`=1: state RUN, `wcnt`=0, watchdog count 0, `stall_timeout`=0. Combinational outputs `stall`, `flush` and `new_pc` are forced 0 while `rst`=1. Reset mid-WAIT abandons the wait; after reset deassert, a still-high `mem_req_i` starts a fresh full wait.

## Timing
- `stall`, `flush` and `new_pc` are combinational from the inputs and the registered state, with zero-cycle latency to the pipeline registers.
- The MEM access completes in the cycle after the last wait cycle: exactly MEM_WAIT stalled cycles per access.
- `flush` lasts exactly one cycle per exception cycle. A held `excepttype_i` flushes every cycle it is held.
- Back-to-back accesses: RUN→WAIT…→DONE→RUN; the next access begins its wait in the RUN cycle following DONE.

## Configuration
- `STALL_WDT_EN` defined:
  - a 16-bit counter increments each cycle `stall`≠0 and clears when `stall`=0 or `flush`=1;
  - on reaching STALL_LIMIT, `stall_timeout` <= 1 and stays set until `rst`;
  - the counter saturates at STALL_LIMIT.
- Undefined: no counter is built and `stall_timeout` is tied to 0.

## Test plan
- MEM_WAIT=2, `mem_req_i` high for 3 cycles → `stall`=6'b011111 for 2 cycles, then 6'b000000; state RUN→WAIT→DONE→RUN.
- `stallreq_id` and `stallreq_ex` both high, no MEM access → `stall`=6'b001111; drop `stallreq_ex` → 6'b000111.
- Mid-WAIT, `excepttype_i`=32'h0000_0008 → same cycle `flush`=1, `stall`=0, `new_pc`=32'h0000_0020; next cycle state RUN and `flush`=0.
- `excepttype_i`=32'h0000_000e, `cp0_epc_i`=32'h0000_1234 → `new_pc`=32'h0000_1234 for one cycle.
- `rst` asserted during WAIT with `mem_req_i` held → all outputs 0 while reset is high; after release, a full 2-cycle wait repeats.
- With STALL_WDT_EN and STALL_LIMIT=8, `stallreq_ex` held 10 cycles → `stall_timeout` rises after the 8th stalled cycle and stays 1 after `stallreq_ex` drops.

Source files
------------

// File: rtl/pipe_ctrl.sv
`default_nettype none
// pipe_ctrl: pipeline stall/flush controller with MEM wait states and exception redirect.
// Optional stall watchdog built when STALL_WDT_EN is defined. Rev 1.0
module pipe_ctrl #(
  parameter int          MEM_WAIT    = 2,
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter int          STALL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        mem_req_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout
);

  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] wcnt, wcnt_next;
  logic       exc;
  logic       mem_wait;

  assign exc = (excepttype_i != 32'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wcnt  <= 4'd0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    mem_wait   = 1'b0;
    stall      = 6'b000000;
    flush      = 1'b0;
    new_pc     = 32'd0;

    case (state)
      RUN: begin
        if (mem_req_i && (MEM_WAIT > 0)) begin
          mem_wait   = 1'b1;
          wcnt_next  = 4'(MEM_WAIT - 1);
          state_next = (MEM_WAIT == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        mem_wait  = 1'b1;
        wcnt_next = wcnt - 4'd1;
        if (wcnt == 4'd1) state_next = DONE;
      end
      // DONE ignores mem_req_i so the finishing access cannot retrigger.
      DONE:    state_next = RUN;
      default: state_next = RUN;
    endcase

    if (exc) begin
      state_next = RUN;
      wcnt_next  = 4'd0;
      flush      = 1'b1;
      new_pc     = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
    end else if (mem_wait) begin
      stall = 6'b011111;
    end else if (stallreq_ex) begin
      stall = 6'b001111;
    end else if (stallreq_id) begin
      stall = 6'b000111;
    end

    if (rst) begin
      stall  = 6'b000000;
      flush  = 1'b0;
      new_pc = 32'd0;
    end
  end

`ifdef STALL_WDT_EN
  logic [15:0] wdt_cnt;
  logic        timeout_q;

  // Counter saturates at the limit; the flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt   <= 16'd0;
      timeout_q <= 1'b0;
    end else if (flush || (stall == 6'b000000)) begin
      wdt_cnt <= 16'd0;
    end else if (wdt_cnt != 16'(STALL_LIMIT)) begin
      wdt_cnt <= wdt_cnt + 16'd1;
      if ((wdt_cnt + 16'd1) == 16'(STALL_LIMIT)) timeout_q <= 1'b1;
    end
  end

  assign stall_timeout = timeout_q;
`else
  assign stall_timeout = 1'b0;
`endif

endmodule
`default_nettype wire
